// File: rtl/bus_slave_port.sv
// Serial bus slave endpoint: deserialises a 16-bit LSB-first address, acknowledges
// when the upper bits match SLAVE_ID, then writes or serially returns one byte.
module bus_slave_port #(
  parameter int                 MEM_AW     = 12,
  parameter logic [15-MEM_AW:0] SLAVE_ID   = '0,
  parameter int                 ACK_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              B_UTIL,
  input  logic              B_RW,
  input  logic              B_BUS_IN,
  output logic              B_BUS_OUT,
  output logic              B_ACK,
  output logic              S_BSY,
  output logic              S_WR_STROBE,
  output logic [MEM_AW-1:0] S_ADDR
);

  typedef enum logic [2:0] {IDLE, ADDR, ACKA, WDATA, ACKW, RDATA, DROP} state_t;

  localparam logic [3:0] ACK_LAST = 4'(ACK_CYCLES - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [15:0]       addr_q;
  logic              rw_q;
  logic [6:0]        wdata_q;
  logic [7:0]        shift_q;
  logic              strobe_q;
  logic              drop_ack_q;
  logic [MEM_AW-1:0] saddr_q;

  logic [7:0] mem [2**MEM_AW];

  logic       id_match;
  logic       ack_last;
  logic       mem_we;
  logic [7:0] mem_wdata;

  assign id_match  = (addr_q[15:MEM_AW] == SLAVE_ID);
  assign ack_last  = (cnt_q == ACK_LAST);
  assign mem_we    = (state_q == WDATA) && B_UTIL && (cnt_q == 4'd7);
  assign mem_wdata = {B_BUS_IN, wdata_q};

  // Memory is deliberately outside the reset domain; contents survive RSTN.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[saddr_q] <= mem_wdata;
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      shift_q    <= '0;
      strobe_q   <= 1'b0;
      drop_ack_q <= 1'b0;
      saddr_q    <= '0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: if (B_UTIL) begin
          addr_q[0] <= B_BUS_IN;
          rw_q      <= B_RW;
          cnt_q     <= 4'd1;
          state_q   <= ADDR;
        end
        ADDR: if (!B_UTIL) begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end else begin
          addr_q[cnt_q] <= B_BUS_IN;
          if (cnt_q == 4'd15) begin
            cnt_q   <= '0;
            state_q <= ACKA;
          end else cnt_q <= cnt_q + 4'd1;
        end
        ACKA: begin
          if (cnt_q == 4'd0 && id_match) saddr_q <= addr_q[MEM_AW-1:0];
          if (ack_last) begin
            cnt_q <= '0;
            if (!id_match) state_q <= DROP;
            else if (rw_q) state_q <= WDATA;
            else begin
              shift_q <= mem[addr_q[MEM_AW-1:0]];
              state_q <= RDATA;
            end
          end else cnt_q <= cnt_q + 4'd1;
        end
        WDATA: if (B_UTIL) begin
          if (cnt_q == 4'd7) begin
            strobe_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ACKW;
          end else begin
            wdata_q <= {B_BUS_IN, wdata_q[6:1]};
            cnt_q   <= cnt_q + 4'd1;
          end
        end
        ACKW: if (ack_last) begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end else cnt_q <= cnt_q + 4'd1;
        RDATA: if (B_UTIL) begin
          shift_q <= {shift_q[6:0], 1'b0};
          if (cnt_q == 4'd7) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else cnt_q <= cnt_q + 4'd1;
        end
        // Shadow the addressed slave's data and write-ACK phases so the data bits
        // are never mistaken for the start of a new address.
        DROP: if (drop_ack_q) begin
          if (ack_last) begin
            drop_ack_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end else cnt_q <= cnt_q + 4'd1;
        end else if (B_UTIL) begin
          if (cnt_q == 4'd7) begin
            cnt_q <= '0;
            if (rw_q) drop_ack_q <= 1'b1;
            else state_q <= IDLE;
          end else cnt_q <= cnt_q + 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign B_BUS_OUT   = (state_q == RDATA) && shift_q[7];
  assign B_ACK       = ((state_q == ACKA) && id_match) || (state_q == ACKW);
  assign S_BSY       = (state_q != IDLE);
  assign S_WR_STROBE = strobe_q;
  assign S_ADDR      = saddr_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed bench for bus_slave_port: table of whole frames plus hand-written
// sequences for reset, address abort, master HOLD and mid-write reset.
module tb_bus_slave_port;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        B_UTIL;
  logic        B_RW;
  logic        B_BUS_IN;
  logic        B_BUS_OUT;
  logic        B_ACK;
  logic        S_BSY;
  logic        S_WR_STROBE;
  logic [11:0] S_ADDR;

  int n_chk  = 0;
  int n_fail = 0;

  bus_slave_port #(.MEM_AW(12), .SLAVE_ID(4'h0), .ACK_CYCLES(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .B_UTIL(B_UTIL), .B_RW(B_RW), .B_BUS_IN(B_BUS_IN),
    .B_BUS_OUT(B_BUS_OUT), .B_ACK(B_ACK), .S_BSY(S_BSY),
    .S_WR_STROBE(S_WR_STROBE), .S_ADDR(S_ADDR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  wd;
    int          hold;
    int          acks;
    int          stbs;
    logic [7:0]  rd;
    logic [11:0] saddr;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full frame; outputs are sampled on falling edges, inputs driven there too.
  task automatic frame(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                       input int hold, output int acks, output int stbs,
                       output logic [7:0] rd, output logic hold_ok, output logic end_idle);
    logic hv;
    acks = 0; stbs = 0; rd = '0; hold_ok = 1'b1; hv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      acks += int'(B_ACK); stbs += int'(S_WR_STROBE);
      B_UTIL = 1'b1; B_RW = rw; B_BUS_IN = a[i];
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      acks += int'(B_ACK); stbs += int'(S_WR_STROBE);
      B_UTIL = 1'b0; B_RW = 1'b0; B_BUS_IN = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (hold != 0 && i == 3) begin
        for (int h = 0; h < hold; h++) begin
          @(negedge CLK);
          acks += int'(B_ACK); stbs += int'(S_WR_STROBE);
          if (h == 0) hv = B_BUS_OUT;
          else if (B_BUS_OUT !== hv) hold_ok = 1'b0;
          B_UTIL = 1'b0; B_BUS_IN = 1'b0;
        end
      end
      @(negedge CLK);
      acks += int'(B_ACK); stbs += int'(S_WR_STROBE);
      if (hold != 0 && i == 3 && B_BUS_OUT !== hv) hold_ok = 1'b0;
      rd = {rd[6:0], B_BUS_OUT};
      B_UTIL = 1'b1; B_BUS_IN = wd[i];
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      acks += int'(B_ACK); stbs += int'(S_WR_STROBE);
      B_UTIL = 1'b0; B_BUS_IN = 1'b0;
    end
    end_idle = !S_BSY && !B_BUS_OUT;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int acks, stbs;
    logic [7:0] rd;
    logic hold_ok, end_idle;
    frame(v.a, v.rw, v.wd, v.hold, acks, stbs, rd, hold_ok, end_idle);
    check({tag, " ack_cycles"}, 32'(acks), 32'(v.acks));
    check({tag, " strobes"}, 32'(stbs), 32'(v.stbs));
    check({tag, " read_byte"}, 32'(rd), 32'(v.rd));
    check({tag, " s_addr"}, 32'(S_ADDR), 32'(v.saddr));
    check({tag, " idle_after"}, 32'(end_idle), 32'd1);
    if (v.hold != 0) check({tag, " hold_stable"}, 32'(hold_ok), 32'd1);
  endtask

  initial begin
    int acks;
    vec_t v;

    tbl[0] = '{16'h0001, 1'b1, 8'h3C, 0, 8, 1, 8'h00, 12'h001};
    tbl[1] = '{16'h0001, 1'b0, 8'h00, 0, 4, 0, 8'h3C, 12'h001};
    tbl[2] = '{16'h0123, 1'b1, 8'hA5, 0, 8, 1, 8'h00, 12'h123};
    tbl[3] = '{16'h0123, 1'b0, 8'h00, 0, 4, 0, 8'hA5, 12'h123};
    tbl[4] = '{16'h0123, 1'b0, 8'h00, 5, 4, 0, 8'hA5, 12'h123};
    tbl[5] = '{16'h1123, 1'b1, 8'h5A, 0, 0, 0, 8'h00, 12'h123};
    tbl[6] = '{16'h0123, 1'b0, 8'h00, 0, 4, 0, 8'hA5, 12'h123};
    tbl[7] = '{16'h0FFF, 1'b1, 8'h81, 0, 8, 1, 8'h00, 12'hFFF};
    tbl[8] = '{16'h0FFF, 1'b0, 8'h00, 0, 4, 0, 8'h81, 12'hFFF};
    tbl[9] = '{16'h1FFF, 1'b0, 8'h00, 0, 0, 0, 8'h00, 12'hFFF};

    RSTN = 1'b1; B_UTIL = 1'b0; B_RW = 1'b0; B_BUS_IN = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset bus_out", 32'(B_BUS_OUT), 32'd0);
    check("reset ack", 32'(B_ACK), 32'd0);
    check("reset bsy", 32'(S_BSY), 32'd0);
    check("reset strobe", 32'(S_WR_STROBE), 32'd0);
    check("reset s_addr", 32'(S_ADDR), 32'd0);
    RSTN = 1'b0;
    @(negedge CLK);

    // Address abort after 9 bits
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      acks += int'(B_ACK);
      B_UTIL = 1'b1; B_RW = 1'b1; B_BUS_IN = i[0];
    end
    @(negedge CLK);
    check("abort busy_mid", 32'(S_BSY), 32'd1);
    B_UTIL = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      acks += int'(B_ACK);
    end
    check("abort ack", 32'(acks), 32'd0);
    check("abort idle", 32'(S_BSY), 32'd0);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset during write data: write 0xFF to 0x0123, reset after 5 data bits
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      B_UTIL = 1'b1; B_RW = 1'b1; B_BUS_IN = (i == 0 || i == 1 || i == 5 || i == 8);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      B_UTIL = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      B_UTIL = 1'b1; B_BUS_IN = 1'b1;
    end
    @(posedge CLK);
    #2;
    check("midrst busy_before", 32'(S_BSY), 32'd1);
    RSTN = 1'b1;
    #1;
    check("midrst bsy", 32'(S_BSY), 32'd0);
    check("midrst ack", 32'(B_ACK), 32'd0);
    check("midrst bus_out", 32'(B_BUS_OUT), 32'd0);
    check("midrst strobe", 32'(S_WR_STROBE), 32'd0);
    check("midrst s_addr", 32'(S_ADDR), 32'd0);
    B_UTIL = 1'b0; B_BUS_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b0;

    v = '{16'h0123, 1'b0, 8'h00, 0, 4, 0, 8'hA5, 12'h123};
    run_vec(v, "postrst_read_old");
    v = '{16'h0123, 1'b1, 8'h77, 0, 8, 1, 8'h00, 12'h123};
    run_vec(v, "postrst_write");
    v = '{16'h0123, 1'b0, 8'h00, 0, 4, 0, 8'h77, 12'h123};
    run_vec(v, "postrst_read_new");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
